// File: rtl/comm_ctrl.sv
// Byte-command controller for an output mux: reads and writes the per-output
// enable mask and input-selector map over a one-byte-at-a-time rx/tx link.
module comm_ctrl #(
  parameter int          OUTPUT_COUNT   = 16,
  parameter int          INPUT_COUNT    = 4,
  parameter logic [63:0] ENABLE_INIT    = 64'hAA55,
  parameter int          TIMEOUT_CYCLES = 65535,
  localparam int         SEL_W          = $clog2(INPUT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [OUTPUT_COUNT-1:0]       enable_mask,
  output logic [OUTPUT_COUNT*SEL_W-1:0] pin_map,
  output logic                          err
);
  localparam int MASK_BYTES = OUTPUT_COUNT / 8;
  localparam int MAP_BITS   = OUTPUT_COUNT * SEL_W;
  localparam int MAP_BYTES  = (MAP_BITS + 7) / 8;
  localparam int STAGE_W    = MAP_BYTES * 8;
  localparam int CNT_W      = $clog2(MAP_BYTES + 1);
  localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SEL_N      = 1 << SEL_W;

  // One bit per encodable selector value: set when that value names a real input.
  localparam logic [SEL_N-1:0] SEL_OK = SEL_N'((64'd1 << INPUT_COUNT) - 64'd1);

  localparam logic [7:0] CMD_RD_MASK = 8'h01;
  localparam logic [7:0] CMD_RD_MAP  = 8'h02;
  localparam logic [7:0] CMD_WR_MASK = 8'h03;
  localparam logic [7:0] CMD_WR_MAP  = 8'h04;
  localparam logic [7:0] ACK         = 8'h06;
  localparam logic [7:0] NAK         = 8'h15;

  function automatic logic [MAP_BITS-1:0] map_init();
    logic [MAP_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++) v[i*SEL_W +: SEL_W] = SEL_W'(i % INPUT_COUNT);
    return v;
  endfunction

  localparam logic [MAP_BITS-1:0] MAP_INIT = map_init();

  typedef enum logic [2:0] {
    S_IDLE, S_RX_PAYLOAD, S_TX_LOAD, S_TX_GUARD, S_TX_WAIT
  } state_t;

  state_t                  r_state, w_state_next;
  logic [STAGE_W-1:0]      r_stage;
  logic [STAGE_W-1:0]      r_reply;
  logic [CNT_W-1:0]        r_byte_cnt;
  logic [CNT_W-1:0]        r_tx_left;
  logic [TO_W-1:0]         r_timeout;
  logic                    r_is_map;
  logic [7:0]              r_tx_data;
  logic                    r_tx_start;
  logic                    r_err;
  logic [OUTPUT_COUNT-1:0] r_mask;
  logic [MAP_BITS-1:0]     r_map;

  logic [STAGE_W-1:0]      w_stage_full;
  logic [OUTPUT_COUNT-1:0] w_sel_bad;
  logic                    w_pad_bad;
  logic                    w_map_bad;
  logic                    w_cmd_write;
  logic                    w_last;
  logic                    w_timeout;
  logic                    w_tx_fire;
  logic                    w_err_next;
  logic                    w_commit_mask;
  logic                    w_commit_map;
  logic                    w_reply_load;
  logic [STAGE_W-1:0]      w_reply_val;
  logic [CNT_W-1:0]        w_reply_len;

  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign err         = r_err;
  assign enable_mask = r_mask;
  assign pin_map     = r_map;

  // Staging value including the byte arriving this cycle, so commit needs no extra cycle.
  assign w_stage_full = (r_stage << 8) | STAGE_W'(rx_data);
  assign w_cmd_write  = (rx_data == CMD_WR_MASK) || (rx_data == CMD_WR_MAP);
  assign w_last       = r_byte_cnt == (r_is_map ? CNT_W'(MAP_BYTES - 1) : CNT_W'(MASK_BYTES - 1));
  assign w_timeout    = !rx_valid && (r_timeout == TO_W'(TIMEOUT_CYCLES - 1));

  for (genvar gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_sel_chk
    assign w_sel_bad[gi] = !SEL_OK[w_stage_full[gi*SEL_W +: SEL_W]];
  end

  if (STAGE_W > MAP_BITS) begin : g_pad
    assign w_pad_bad = |w_stage_full[STAGE_W-1:MAP_BITS];
  end else begin : g_no_pad
    assign w_pad_bad = 1'b0;
  end

  assign w_map_bad = w_pad_bad || (|w_sel_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (rx_valid) w_state_next = w_cmd_write ? S_RX_PAYLOAD : S_TX_LOAD;
      S_RX_PAYLOAD: begin
        if (rx_valid && w_last) w_state_next = S_TX_LOAD;
        else if (w_timeout)     w_state_next = S_IDLE;
      end
      S_TX_LOAD:    if (!tx_busy) w_state_next = S_TX_GUARD;
      S_TX_GUARD:   w_state_next = S_TX_WAIT;
      S_TX_WAIT:    if (!tx_busy) w_state_next = (r_tx_left != '0) ? S_TX_LOAD : S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_fire     = 1'b0;
    w_err_next    = 1'b0;
    w_commit_mask = 1'b0;
    w_commit_map  = 1'b0;
    w_reply_load  = 1'b0;
    w_reply_val   = '0;
    w_reply_len   = '0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && !w_cmd_write) begin
          w_reply_load = 1'b1;
          if (rx_data == CMD_RD_MASK) begin
            w_reply_val = STAGE_W'(r_mask) << (STAGE_W - OUTPUT_COUNT);
            w_reply_len = CNT_W'(MASK_BYTES);
          end else if (rx_data == CMD_RD_MAP) begin
            w_reply_val = STAGE_W'(r_map);
            w_reply_len = CNT_W'(MAP_BYTES);
          end else begin
            w_reply_val = STAGE_W'(NAK) << (STAGE_W - 8);
            w_reply_len = CNT_W'(1);
            w_err_next  = 1'b1;
          end
        end
      end
      S_RX_PAYLOAD: begin
        if (rx_valid && w_last) begin
          w_reply_load = 1'b1;
          w_reply_len  = CNT_W'(1);
          if (r_is_map && w_map_bad) begin
            w_reply_val = STAGE_W'(NAK) << (STAGE_W - 8);
            w_err_next  = 1'b1;
          end else begin
            w_reply_val   = STAGE_W'(ACK) << (STAGE_W - 8);
            w_commit_mask = !r_is_map;
            w_commit_map  = r_is_map;
          end
        end else if (w_timeout) begin
          w_err_next = 1'b1;
        end
      end
      S_TX_LOAD: begin
        w_tx_fire  = !tx_busy;
        w_err_next = rx_valid;
      end
      default: w_err_next = rx_valid;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage    <= '0;
      r_reply    <= '0;
      r_byte_cnt <= '0;
      r_tx_left  <= '0;
      r_timeout  <= '0;
      r_is_map   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      r_mask     <= ENABLE_INIT[OUTPUT_COUNT-1:0];
      r_map      <= MAP_INIT;
    end else begin
      r_tx_start <= w_tx_fire;
      r_err      <= w_err_next;
      if (w_reply_load) begin
        r_reply   <= w_reply_val;
        r_tx_left <= w_reply_len;
      end else if (w_tx_fire) begin
        r_tx_data <= r_reply[STAGE_W-1 -: 8];
        r_reply   <= r_reply << 8;
        r_tx_left <= r_tx_left - CNT_W'(1);
      end
      if (r_state == S_IDLE && rx_valid && w_cmd_write) begin
        r_stage    <= '0;
        r_byte_cnt <= '0;
        r_timeout  <= '0;
        r_is_map   <= (rx_data == CMD_WR_MAP);
      end else if (r_state == S_RX_PAYLOAD) begin
        if (rx_valid) begin
          r_stage    <= w_last ? '0 : w_stage_full;
          r_byte_cnt <= r_byte_cnt + CNT_W'(1);
          r_timeout  <= '0;
        end else if (w_timeout) begin
          r_stage   <= '0;
          r_timeout <= '0;
        end else begin
          r_timeout <= r_timeout + TO_W'(1);
        end
      end
      if (w_commit_mask) r_mask <= w_stage_full[OUTPUT_COUNT-1:0];
      if (w_commit_map)  r_map  <= w_stage_full[MAP_BITS-1:0];
    end
  end
endmodule

// File: tb/tb_comm_ctrl.sv
// Scoreboard bench for comm_ctrl: dut0 uses default parameters, dut1 uses
// INPUT_COUNT=3 and TIMEOUT_CYCLES=100.
`timescale 1ns/1ps
module tb_comm_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  rx_valid;
  logic [1:0]  tx_start;
  logic [1:0]  tx_busy;
  logic [1:0]  err;
  logic [7:0]  rx_data [2];
  logic [7:0]  tx_data [2];
  logic [15:0] mask    [2];
  logic [31:0] pmap    [2];

  int busy_cnt [2] = '{0, 0};
  int err_cnt  [2] = '{0, 0};
  int tx_cnt   [2] = '{0, 0};
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];
  logic [31:0] map_init0, map_init1;

  comm_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
    .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0]),
    .enable_mask(mask[0]), .pin_map(pmap[0]), .err(err[0])
  );

  comm_ctrl #(.INPUT_COUNT(3), .TIMEOUT_CYCLES(100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
    .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1]),
    .enable_mask(mask[1]), .pin_map(pmap[1]), .err(err[1])
  );

  // Transmitter model: busy for four cycles after each accepted start.
  assign tx_busy[0] = busy_cnt[0] != 0;
  assign tx_busy[1] = busy_cnt[1] != 0;
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tx_start[d])       busy_cnt[d] <= 4;
      else if (busy_cnt[d] > 0) busy_cnt[d] <= busy_cnt[d] - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: every transmitted byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    logic [7:0] want;
    bit         have;
    for (int d = 0; d < 2; d++) begin
      if (err[d]) err_cnt[d]++;
      if (tx_start[d]) begin
        have = 1'b0;
        want = 8'h00;
        if (d == 0 && exp_q0.size() > 0) begin want = exp_q0.pop_front(); have = 1'b1; end
        if (d == 1 && exp_q1.size() > 0) begin want = exp_q1.pop_front(); have = 1'b1; end
        tx_cnt[d]++;
        chk($sformatf("start_while_busy_dut%0d", d), 64'(tx_busy[d]), 64'd0);
        if (have) begin
          chk($sformatf("tx_byte_dut%0d", d), 64'(tx_data[d]), 64'(want));
          $display("dut%0d tx 0x%02h (expected 0x%02h)", d, tx_data[d], want);
        end else begin
          n_checks++;
          $display("FAIL unexpected_tx_dut%0d: got 0x%02h, required no byte", d, tx_data[d]);
        end
      end
    end
  end

  task automatic push(input int d, input logic [7:0] b);
    if (d == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endtask

  task automatic send(input int d, input logic [7:0] b);
    rx_data[d]  = b;
    rx_valid[d] = 1'b1;
    @(negedge clk);
    rx_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int k;
    int qs;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      qs = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (qs == 0 && !tx_busy[d] && !tx_start[d]) break;
    end
    if (k == 400) begin
      n_checks++;
      $display("FAIL wait_idle_dut%0d: reply not drained within 400 cycles", d);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t0;
    int k;
    rst_n      = 1'b0;
    rx_valid   = 2'b00;
    rx_data[0] = 8'h00;
    rx_data[1] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      map_init0[2*i +: 2] = 2'(i % 4);
      map_init1[2*i +: 2] = 2'(i % 3);
    end
    repeat (3) @(negedge clk);
    chk("rst_mask0",    64'(mask[0]),     64'hAA55);
    chk("rst_mask1",    64'(mask[1]),     64'hAA55);
    chk("rst_map0",     64'(pmap[0]),     64'(map_init0));
    chk("rst_map1",     64'(pmap[1]),     64'(map_init1));
    chk("rst_txdata0",  64'(tx_data[0]),  64'h0);
    chk("rst_txstart0", 64'(tx_start[0]), 64'h0);
    chk("rst_err0",     64'(err[0]),      64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // READ_MASK after reset, with command-to-tx_start latency
    push(0, 8'hAA); push(0, 8'h55);
    send(0, 8'h01);
    chk("lat_not_early", 64'(tx_start[0]), 64'd0);
    @(negedge clk);
    chk("lat_2cyc", 64'(tx_start[0]), 64'd1);
    wait_idle(0);

    // READ_MAP of reset selectors (i mod 4 -> every byte 0xE4)
    for (int i = 0; i < 4; i++) push(0, 8'hE4);
    send(0, 8'h02);
    wait_idle(0);

    // WRITE_MASK, commit timing, readback
    send(0, 8'h03);
    send(0, 8'h12);
    chk("mask_unchanged_mid", 64'(mask[0]), 64'hAA55);
    push(0, 8'h06);
    send(0, 8'h34);
    chk("mask_commit_1cyc", 64'(mask[0]), 64'h1234);
    wait_idle(0);
    push(0, 8'h12); push(0, 8'h34);
    send(0, 8'h01);
    wait_idle(0);

    // WRITE_MAP valid, readback
    send(0, 8'h04); send(0, 8'h12); send(0, 8'h34); send(0, 8'h56);
    chk("map_unchanged_mid", 64'(pmap[0]), 64'(map_init0));
    push(0, 8'h06);
    send(0, 8'h78);
    chk("map_commit", 64'(pmap[0]), 64'h12345678);
    wait_idle(0);
    push(0, 8'h12); push(0, 8'h34); push(0, 8'h56); push(0, 8'h78);
    send(0, 8'h02);
    wait_idle(0);

    // Unknown command, then a byte arriving during the NAK reply
    e0 = err_cnt[0];
    t0 = tx_cnt[0];
    push(0, 8'h15);
    send(0, 8'h7F);
    repeat (2) @(negedge clk);
    send(0, 8'h01);
    wait_idle(0);
    chk("bad_cmd_err_count", 64'(err_cnt[0] - e0), 64'd2);
    chk("bad_cmd_tx_count",  64'(tx_cnt[0] - t0),  64'd1);

    // Reset between payload bytes of WRITE_MASK
    send(0, 8'h03);
    send(0, 8'h56);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mask", 64'(mask[0]), 64'hAA55);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = tx_cnt[0];
    repeat (10) @(negedge clk);
    chk("rst_mid_no_tx",   64'(tx_cnt[0] - t0), 64'd0);
    chk("rst_mid_mask_hold", 64'(mask[0]), 64'hAA55);
    push(0, 8'hAA); push(0, 8'h55);
    send(0, 8'h01);
    wait_idle(0);

    // dut1: WRITE_MAP with selector value 3 is rejected
    e0 = err_cnt[1];
    send(1, 8'h04); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
    push(1, 8'h15);
    send(1, 8'h03);
    chk("map_bad_unchanged", 64'(pmap[1]), 64'(map_init1));
    wait_idle(1);
    chk("map_bad_err", 64'(err_cnt[1] - e0), 64'd1);

    // dut1: selectors up to 2 are accepted
    send(1, 8'h04); send(1, 8'h24); send(1, 8'h24); send(1, 8'h24);
    push(1, 8'h06);
    send(1, 8'h24);
    chk("map_ok_commit", 64'(pmap[1]), 64'h24242424);
    wait_idle(1);
    for (int i = 0; i < 4; i++) push(1, 8'h24);
    send(1, 8'h02);
    wait_idle(1);

    // dut1: payload timeout after 100 idle cycles
    e0 = err_cnt[1];
    t0 = tx_cnt[1];
    send(1, 8'h03);
    send(1, 8'h12);
    for (k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (err[1]) break;
    end
    chk("timeout_cycles", 64'(k), 64'd100);
    repeat (5) @(negedge clk);
    chk("timeout_mask", 64'(mask[1]), 64'hAA55);
    chk("timeout_no_tx", 64'(tx_cnt[1] - t0), 64'd0);
    chk("timeout_err_count", 64'(err_cnt[1] - e0), 64'd1);
    push(1, 8'hAA); push(1, 8'h55);
    send(1, 8'h01);
    wait_idle(1);

    chk("scoreboard0_empty", 64'(exp_q0.size()), 64'd0);
    chk("scoreboard1_empty", 64'(exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
